// File: rtl/uart_alu_host_pkg.sv
// rtl/uart_alu_host_pkg.sv - shared definitions for the UART ALU command link
//
// Purpose: state encoding of the host FSM, default widths, and the byte
//          order of a command frame (shared with the receiving interface).
// Ports:   none (package).
package uart_alu_host_pkg;

  localparam int N_DATA_DEF       = 8;
  localparam int NB_OPERATION_DEF = 6;

  // Position of each byte within a command frame.
  localparam int DATA_A  = 0;
  localparam int DATA_B  = 1;
  localparam int DATA_OP = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_WAIT_A,
    ST_SEND_B,
    ST_WAIT_B,
    ST_SEND_OP,
    ST_WAIT_OP,
    ST_WAIT_RES
  } state_t;

endpackage

// File: rtl/uart_alu_host_timeout_counter.sv
// rtl/uart_alu_host_timeout_counter.sv - result wait timeout counter
//
// Purpose: counts enabled cycles and flags the terminal count
//          (TIMEOUT_CYCLES-1). Never wraps on its own in normal use: the
//          owner leaves the counting state on the terminal cycle.
// Ports:   i_clk, i_rst (async, active-high)
//          i_clear    - synchronous clear, has priority over i_enable
//          i_enable   - count this cycle
//          o_terminal - combinational, high while enabled at terminal count
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + W'(1);
    end
  end

  assign o_terminal = i_enable && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_alu_host.sv
// rtl/uart_alu_host.sv - host-side initiator for the UART ALU command link
//
// Purpose: on i_start captures (A, B, OP), sends them as three UART bytes in
//          order A, B, OP through the tx start/done handshake, then waits for
//          one result byte from the receiver or aborts on timeout.
// Ports:   i_clk, i_rst (async, active-high)
//          i_start, i_data_a, i_data_b, i_data_op - command request and operands
//          o_busy                                 - high outside IDLE
//          o_tx_data, o_tx_start, i_tx_done       - UART transmitter handshake
//          i_rx_data, i_rx_done                   - UART receiver word/strobe
//          o_result, o_result_valid               - result byte and its pulse
//          o_timeout                              - result wait aborted
//          o_parity_err                           - even parity failed on result
module uart_alu_host
  import uart_alu_host_pkg::*;
#(
  parameter int N_DATA         = N_DATA_DEF,
  parameter int PARITY_CHECK   = 0,
  parameter int NB_OPERATION   = NB_OPERATION_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [N_DATA-1:0]          i_data_a,
  input  logic [N_DATA-1:0]          i_data_b,
  input  logic [NB_OPERATION-1:0]    i_data_op,
  output logic                       o_busy,
  output logic [N_DATA-1:0]          o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
  input  logic                       i_rx_done,
  output logic [N_DATA-1:0]          o_result,
  output logic                       o_result_valid,
  output logic                       o_timeout,
  output logic                       o_parity_err
);

  state_t state, state_next;

  // Operand A goes straight into o_tx_data on the capture edge, so only B
  // and OP need their own holding registers.
  logic [N_DATA-1:0]       data_b_q;
  logic [NB_OPERATION-1:0] data_op_q;

  logic              load_cmd;
  logic              load_tx;
  logic [1:0]        tx_sel;
  logic [N_DATA-1:0] tx_next;
  logic              cnt_clear;
  logic              cnt_terminal;
  logic              take_result;
  logic              take_timeout;
  logic              parity_bad;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (cnt_clear),
    .i_enable  (state == ST_WAIT_RES),
    .o_terminal(cnt_terminal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_cmd     = 1'b0;
    load_tx      = 1'b0;
    tx_sel       = 2'(DATA_A);
    cnt_clear    = 1'b0;
    take_result  = 1'b0;
    take_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          load_cmd   = 1'b1;
          load_tx    = 1'b1;
          tx_sel     = 2'(DATA_A);
          state_next = ST_SEND_A;
        end
      end
      ST_SEND_A:  state_next = ST_WAIT_A;
      ST_WAIT_A: begin
        if (i_tx_done) begin
          load_tx    = 1'b1;
          tx_sel     = 2'(DATA_B);
          state_next = ST_SEND_B;
        end
      end
      ST_SEND_B:  state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_tx_done) begin
          load_tx    = 1'b1;
          tx_sel     = 2'(DATA_OP);
          state_next = ST_SEND_OP;
        end
      end
      ST_SEND_OP: state_next = ST_WAIT_OP;
      ST_WAIT_OP: begin
        if (i_tx_done) begin
          cnt_clear  = 1'b1;
          state_next = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        // A result arriving on the terminal-count cycle beats the timeout.
        if (i_rx_done) begin
          take_result = 1'b1;
          state_next  = ST_IDLE;
        end else if (cnt_terminal) begin
          take_timeout = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (tx_sel)
      2'(DATA_A): tx_next = i_data_a;
      2'(DATA_B): tx_next = data_b_q;
      default:    tx_next = N_DATA'(data_op_q);
    endcase
  end

  assign parity_bad = (PARITY_CHECK != 0) && (^i_rx_data);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_b_q       <= '0;
      data_op_q      <= '0;
      o_tx_data      <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_timeout      <= 1'b0;
      o_parity_err   <= 1'b0;
    end else begin
      o_result_valid <= take_result;
      o_parity_err   <= take_result && parity_bad;
      o_timeout      <= take_timeout;
      if (load_cmd) begin
        data_b_q  <= i_data_b;
        data_op_q <= i_data_op;
      end
      if (load_tx) begin
        o_tx_data <= tx_next;
      end
      if (take_result) begin
        o_result <= i_rx_data[N_DATA-1:0];
      end
    end
  end

  assign o_busy     = (state != ST_IDLE);
  assign o_tx_start = (state == ST_SEND_A) || (state == ST_SEND_B) ||
                      (state == ST_SEND_OP);

endmodule

// File: tb/tb_uart_alu_host.sv
// tb/tb_uart_alu_host.sv - self-checking bench for uart_alu_host
module tb_uart_alu_host;

  localparam int N  = 8;
  localparam int P  = 1;
  localparam int NB = 6;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [N-1:0]  a_in = '0;
  logic [N-1:0]  b_in = '0;
  logic [NB-1:0] op_in = '0;
  logic          busy;
  logic [N-1:0]  tx_data;
  logic          tx_start;
  logic          tx_done = 1'b0;
  logic [N+P-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic [N-1:0]  result;
  logic          rvalid;
  logic          tout;
  logic          perr;

  int checks = 0;
  int errors = 0;

  uart_alu_host #(
    .N_DATA(N), .PARITY_CHECK(P), .NB_OPERATION(NB), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .i_data_a(a_in), .i_data_b(b_in), .i_data_op(op_in),
    .o_busy(busy), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_result(result), .o_result_valid(rvalid), .o_timeout(tout),
    .o_parity_err(perr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Word with correct even parity over all N+1 bits.
  function automatic logic [N:0] even_word(input logic [N-1:0] d);
    return {^d, d};
  endfunction

  // Plays the master plus the uart_tx side for one frame. Returns the three
  // bytes seen on each tx_start, the number of late/missing tx_start events
  // and the number of protocol violations observed while waiting.
  // Returns at the negedge right after WAIT_RES is entered.
  task automatic do_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [NB-1:0] op, input bit stray,
                          output logic [N-1:0] g0, output logic [N-1:0] g1,
                          output logic [N-1:0] g2, output int lat_bad,
                          output int viol);
    logic [N-1:0] gb [3];
    int w;
    int d;
    lat_bad = 0;
    viol = 0;
    a_in = a; b_in = b; op_in = op; i_start = 1'b1;
    step();
    i_start = 1'b0;
    a_in = N'($urandom); b_in = N'($urandom); op_in = NB'($urandom);
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 50) begin
        step();
        w++;
      end
      if (w != 0) lat_bad++;
      gb[k] = tx_data;
      if (busy !== 1'b1) viol++;
      if (stray && k == 0) tx_done = 1'b1;
      if (stray && k == 2) i_start = 1'b1;
      step();
      tx_done = 1'b0;
      i_start = 1'b0;
      if (tx_start !== 1'b0 || tx_data !== gb[k]) viol++;
      d = $urandom_range(0, 3);
      if (stray && k == 1) d = d + 2;
      for (int j = 0; j < d; j++) begin
        if (stray && k == 1 && j == 0) begin
          rx_data = 9'h0AA;
          rx_done = 1'b1;
        end
        step();
        rx_done = 1'b0;
        if (tx_start !== 1'b0 || tx_data !== gb[k] || busy !== 1'b1 ||
            rvalid !== 1'b0) viol++;
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    g0 = gb[0]; g1 = gb[1]; g2 = gb[2];
  endtask

  task automatic send_rx(input logic [N:0] word);
    rx_data = word;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_data = (N+1)'($urandom);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, tx_start, rvalid, tout, perr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000", {busy, tx_start, rvalid, tout, perr});
    end
    checks++;
    if ({tx_data, result} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0000", {tx_data, result});
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] g0, g1, g2;
    int lb, vi;
    do_frame(8'h05, 8'h03, 6'h20, 1'b0, g0, g1, g2, lb, vi);
    checks++;
    if ({g0, g1, g2} !== 24'h050320) begin
      errors++;
      $display("FAIL basic_bytes got=%h want=050320", {g0, g1, g2});
    end
    checks++;
    if (lb !== 0 || vi !== 0) begin
      errors++;
      $display("FAIL basic_handshake late=%0d viol=%0d want 0/0", lb, vi);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_wait got=%b want=1", busy);
    end
    repeat (3) step();
    send_rx(even_word(8'h08));
    checks++;
    if ({result, rvalid, perr, busy} !== {8'h08, 3'b100}) begin
      errors++;
      $display("FAIL basic_result got=%h/%b%b%b want=08/100", result, rvalid, perr, busy);
    end
    step();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_pulse got=%b want=0", rvalid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, res, g0, g1, g2;
    logic [NB-1:0] op;
    logic bad;
    int lb, vi;
    for (int it = 0; it < 6; it++) begin
      a = N'($urandom); b = N'($urandom); op = NB'($urandom);
      res = N'($urandom); bad = 1'($urandom_range(0, 1));
      do_frame(a, b, op, 1'b0, g0, g1, g2, lb, vi);
      checks++;
      if ({g0, g1, g2} !== {a, b, N'(op)} || lb !== 0 || vi !== 0) begin
        errors++;
        $display("FAIL rand_frame[%0d] got=%h late=%0d viol=%0d want=%h", it,
                 {g0, g1, g2}, lb, vi, {a, b, N'(op)});
      end
      repeat ($urandom_range(0, 10)) step();
      send_rx({(^res) ^ bad, res});
      checks++;
      if ({result, rvalid, perr} !== {res, 1'b1, bad}) begin
        errors++;
        $display("FAIL rand_result[%0d] got=%h/%b%b want=%h/1%b", it, result,
                 rvalid, perr, res, bad);
      end
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] prev, g0, g1, g2;
    int lb, vi, k, vcount;
    prev = result;
    do_frame(8'h11, 8'h22, 6'h3F, 1'b0, g0, g1, g2, lb, vi);
    k = 0;
    vcount = 0;
    while (tout !== 1'b1 && k < 40) begin
      if (rvalid === 1'b1) vcount++;
      step();
      k++;
    end
    checks++;
    if (k !== T) begin
      errors++;
      $display("FAIL timeout_latency got=%0d want=%0d", k, T);
    end
    checks++;
    if (vcount !== 0 || rvalid !== 1'b0 || result !== prev || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state valid=%0d/%b result=%h busy=%b want 0/0 %h 0",
               vcount, rvalid, result, busy, prev);
    end
    step();
    checks++;
    if (tout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got=%b want=0", tout);
    end
  endtask

  task automatic test_stray();
    logic [N-1:0] g0, g1, g2;
    int lb, vi;
    do_frame(8'hC3, 8'h5A, 6'h15, 1'b1, g0, g1, g2, lb, vi);
    checks++;
    if ({g0, g1, g2} !== 24'hC35A15 || lb !== 0 || vi !== 0) begin
      errors++;
      $display("FAIL stray_frame got=%h late=%0d viol=%0d want=c35a15", {g0, g1, g2}, lb, vi);
    end
    // i_start held on the cycle the FSM returns to IDLE must not be seen.
    i_start = 1'b1;
    send_rx(even_word(8'h77));
    i_start = 1'b0;
    checks++;
    if ({result, rvalid, busy} !== {8'h77, 2'b10}) begin
      errors++;
      $display("FAIL stray_result got=%h/%b%b want=77/10", result, rvalid, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL stray_no_restart busy=%b tx_start=%b want 0/0", busy, tx_start);
    end
    // Result arriving on the terminal-count cycle.
    do_frame(8'h01, 8'h02, 6'h03, 1'b0, g0, g1, g2, lb, vi);
    repeat (T - 1) step();
    send_rx(even_word(8'h9C));
    checks++;
    if ({result, rvalid, tout} !== {8'h9C, 2'b10}) begin
      errors++;
      $display("FAIL tc_race got=%h/%b%b want=9c/10", result, rvalid, tout);
    end
    step();
    checks++;
    if (tout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tc_race_after tout=%b busy=%b want 0/0", tout, busy);
    end
  endtask

  task automatic test_parity();
    logic [N-1:0] g0, g1, g2;
    int lb, vi;
    do_frame(8'h10, 8'h20, 6'h01, 1'b0, g0, g1, g2, lb, vi);
    send_rx(9'b1_0000_0011);
    checks++;
    if ({result, rvalid, perr} !== {8'h03, 2'b11}) begin
      errors++;
      $display("FAIL parity_bad got=%h/%b%b want=03/11", result, rvalid, perr);
    end
    step();
    checks++;
    if (perr !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse got=%b want=0", perr);
    end
    do_frame(8'h10, 8'h20, 6'h01, 1'b0, g0, g1, g2, lb, vi);
    send_rx(9'b0_0000_0011);
    checks++;
    if ({result, rvalid, perr} !== {8'h03, 2'b10}) begin
      errors++;
      $display("FAIL parity_good got=%h/%b%b want=03/10", result, rvalid, perr);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g0, g1, g2;
    int lb, vi, starts;
    a_in = 8'h5A; b_in = 8'hA5; op_in = 6'h2A; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, tx_start, rvalid, tout, perr, tx_data, result} !== 21'h0) begin
      errors++;
      $display("FAIL rst_async got=%h want=0",
               {busy, tx_start, rvalid, tout, perr, tx_data, result});
    end
    starts = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 3) rst = 1'b0;
      tx_done = j[0];
      if (tx_start === 1'b1 || busy === 1'b1) starts++;
    end
    tx_done = 1'b0;
    step();
    checks++;
    if (starts !== 0) begin
      errors++;
      $display("FAIL rst_no_tx got=%0d want=0", starts);
    end
    do_frame(8'hE7, 8'h18, 6'h33, 1'b0, g0, g1, g2, lb, vi);
    checks++;
    if ({g0, g1, g2} !== 24'hE71833 || lb !== 0 || vi !== 0) begin
      errors++;
      $display("FAIL rst_new_frame got=%h late=%0d viol=%0d want=e71833", {g0, g1, g2}, lb, vi);
    end
    send_rx(even_word(8'h42));
    checks++;
    if ({result, rvalid} !== {8'h42, 1'b1}) begin
      errors++;
      $display("FAIL rst_new_result got=%h/%b want=42/1", result, rvalid);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_random();
    test_timeout();
    test_stray();
    test_parity();
    test_reset_mid();
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_host.md
Name: uart_alu_host

Overview:
Host-side initiator for the UART ALU command link; it is the far end of the receiving interface that collects operand A, operand B and the opcode.
- Takes a captured command (A, B, OP) on a start strobe.
- Serializes it as three UART bytes in the order A, B, OP via the UART transmitter's start/done handshake.
- Waits for the single result byte from the UART receiver and returns it with a valid pulse, or flags a timeout.
- Sits between a test/control master and the uart_tx/uart_rx pair.

Parameters:
N_DATA, 8, UART data byte width and operand/result width
PARITY_CHECK, 0, extra bit on received word (MSB); 1 enables parity error reporting
NB_OPERATION, 6, opcode width; zero-extended to N_DATA on transmit
TIMEOUT_CYCLES, 1000000, clock cycles allowed in WAIT_RES before abort (must be >= 2)

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start  input  1  command request; sampled only in IDLE
i_data_a  input  N_DATA  operand A
i_data_b  input  N_DATA  operand B
i_data_op  input  NB_OPERATION  opcode
o_busy  output  1  high in every state except IDLE
o_tx_data  output  N_DATA  byte to UART transmitter
o_tx_start  output  1  one-cycle transmit request
i_tx_done  input  1  UART transmitter finished current byte
i_rx_data  input  N_DATA+PARITY_CHECK  received word, parity at MSB when present
i_rx_done  input  1  one-cycle received-word strobe
o_result  output  N_DATA  last result byte, held until next result
o_result_valid  output  1  one-cycle pulse with new o_result
o_timeout  output  1  one-cycle pulse on result timeout
o_parity_err  output  1  one-cycle pulse with o_result_valid when even parity fails (tied 0 if PARITY_CHECK=0)

Behaviour:
- Reset values: state IDLE; all outputs 0; command registers 0; timeout counter 0. Reset mid-frame aborts immediately, with no further tx_start.
- States: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES.
- IDLE: when i_start=1, register A, B and OP, then go to SEND_A. Inputs may change after that edge.
- SEND_x: o_tx_start=1 for exactly one cycle, with o_tx_data set to the corresponding byte (OP is zero-extended); next state is WAIT_x.
- o_tx_data is registered and stable from SEND_x through WAIT_x.
- WAIT_x: hold until i_tx_done=1. Transitions are WAIT_A->SEND_B, WAIT_B->SEND_OP, WAIT_OP->WAIT_RES (timeout counter cleared).
- i_tx_done is ignored in SEND_x and outside WAIT_x. Waiting for tx completion has no timeout.
- Latency: i_start at edge n gives o_tx_start high during cycle n+1. The next SEND begins the cycle after i_tx_done.
- WAIT_RES, on i_rx_done=1:
  - o_result <= i_rx_data[N_DATA-1:0]; o_result_valid pulses; go to IDLE.
  - If PARITY_CHECK=1 and XOR of the full word is not 0, o_parity_err pulses at the same time.
- WAIT_RES, no i_rx_done: counter increments. When counter == TIMEOUT_CYCLES-1, o_timeout pulses, go to IDLE, o_result unchanged.
- i_rx_done and timeout in the same cycle: the result wins and o_timeout stays 0.
- i_rx_done in any state other than WAIT_RES is discarded (stale or echo bytes).
- i_start outside IDLE is ignored, with no queueing. i_start in the cycle the FSM returns to IDLE is not seen; it is sampled from the next cycle on.
- The timeout counter width is clog2(TIMEOUT_CYCLES) and saturates only by the transition out of WAIT_RES.

Decomposition:
- Shared header uart_alu_defs.vh holds the state encodings, N_DATA/NB_OPERATION defaults, and the byte order constants DATA_A=0, DATA_B=1, DATA_OP=2, shared with the receiving interface.
- clog2.vh is included for counter sizing.
- One natural sub-module, timeout_counter: clear, enable, terminal-count pulse, parameter TIMEOUT_CYCLES.
- Everything else lives in a single FSM module.

Test Plan:
1. Basic transaction: A=0x05, B=0x03, OP=0x20, i_start. Required response:
   - three o_tx_start pulses carrying 0x05, 0x03, 0x20, each only after i_tx_done;
   - then i_rx_done with 0x08 -> o_result=0x08, one o_result_valid pulse, o_busy falls.
2. Timeout: TIMEOUT_CYCLES=16, full send, no rx -> o_timeout pulses exactly 16 cycles after entering WAIT_RES; no valid pulse; o_result keeps its previous value.
3. Stray, repeated and simultaneous events:
   - i_rx_done=0xAA during WAIT_B and a second i_start during SEND_OP -> both ignored; the frame completes normally.
   - i_rx_done on the terminal-count cycle -> valid pulse and no timeout.
4. Parity: PARITY_CHECK=1, rx word 9'b1_0000_0011 (odd) -> o_result=0x03, o_result_valid and o_parity_err pulse together; word 9'b0_0000_0011 -> no error.
5. Reset mid-frame: assert i_rst asynchronously in WAIT_A -> all outputs 0 immediately, no further o_tx_start. A new command after release sends from byte A.
